gpu_fill_ctrl: RTL and testbench
================================

Name: gpu_fill_ctrl

Overview:
- Owns port A of the 512x16 framebuffer RAM and shares it between two requesters: the CPU word-access path and a rectangle-fill engine.
- The framebuffer is 40x30 cells of 4 bits each, packed 4 cells per 16-bit word and 10 words per row. Word address = y*10 + (x>>2). Cell x%4==0 occupies bits[15:12], x%4==3 occupies bits[3:0].
- The fill engine paints a clipped rectangle with one colour, using read-modify-write on partially covered words. The CPU always has priority.

Parameters:
- COLS, 40, cells per row.
- ROWS, 30, rows of cells.
- WPR, 10, words per row (COLS/4).
- RD_LAT, 1, cycles from RAM address presented to RAM_Q valid.

Ports:
- CLK  in  1  system clock, single clock domain.
- RST_N  in  1  reset, synchronous, active-low.
- CPU_REQ  in  1  CPU accesses RAM this cycle (read or write).
- CPU_WREN  in  1  CPU write strobe; qualified by CPU_REQ.
- CPU_ADDR  in  9  CPU word address.
- CPU_DATA  in  16  CPU write data.
- CPU_Q  out  16  RAM read data, wired directly from RAM_Q.
- FILL_START  in  1  one-cycle request to start a fill; sampled only in IDLE.
- FILL_X0, FILL_X1  in  6  inclusive cell column bounds.
- FILL_Y0, FILL_Y1  in  5  inclusive cell row bounds.
- FILL_COLOR  in  4  colour nibble to paint.
- BUSY  out  1  fill in progress.
- DONE  out  1  one-cycle pulse when a fill completes.
- RAM_ADDR  out  9  RAM port A address.
- RAM_DATA  out  16  RAM port A write data.
- RAM_WREN  out  1  RAM port A write enable.
- RAM_Q  in  16  RAM port A read data.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - state=IDLE; BUSY=0, DONE=0; engine RAM_WREN=0; all engine registers cleared.
  - Reset mid-fill aborts the fill. No further engine writes occur; a partially painted rectangle is left as is.
- Port mux:
  - CPU_REQ=1: RAM_ADDR=CPU_ADDR, RAM_DATA=CPU_DATA, RAM_WREN=CPU_WREN. This path is combinational, so the CPU sees zero added latency.
  - CPU_REQ=0: the mux drives the registered engine signals.
  - When neither requester is active, RAM_WREN=0.
- Fill start: FILL_START=1 in IDLE latches the coordinates and colour, sets BUSY=1 and moves to SETUP. FILL_START while BUSY=1 is ignored.
- SETUP:
  - Clamps: X1=min(X1,COLS-1), Y1=min(Y1,ROWS-1).
  - If X0>X1 or Y0>Y1 after clamping, go to DONE with no RAM write.
  - Otherwise cur_y=Y0, cur_w=X0>>2.
- Per word:
  - mask nibble i is set if X0 <= cur_w*4+i <= X1.
  - fill word = FILL_COLOR replicated into the masked nibbles.
  - Full mask (all 4 nibbles): go straight to WR, with data = colour replicated 4 times.
  - Partial mask: RD (drive address) -> WAIT for RD_LAT cycles -> WR, with data = (RAM_Q & ~mask) | (fill & mask).
- WR:
  - Asserts the engine write for one cycle.
  - Then advances: cur_w++ while cur_w < X1>>2; otherwise cur_w=X0>>2 and cur_y++.
  - After the last word (cur_y=Y1, cur_w=X1>>2), go to DONE.
- Contention (CPU_REQ=1 while the engine is in a state):
  - In RD or WAIT: the engine does not advance and returns to RD, so the read is reissued.
  - In WR of a partial word: the write is dropped and the engine returns to RD, so data a CPU write just placed is merged, never overwritten.
  - In WR of a full word: the engine stalls in WR and writes on the first cycle with CPU_REQ=0.
- DONE: DONE=1 for exactly one cycle, BUSY=0 in that same cycle, then IDLE. A FILL_START in the DONE cycle is ignored.
- Timing:
  - Full-word write: 1 cycle per word.
  - Partial word: 2+RD_LAT cycles per word.
  - Overhead: 1 cycle for SETUP plus 1 cycle for DONE.
- Address arithmetic: cur_y*WPR+cur_w, computed 9 bits wide; the maximum value is 299.

Test Plan:
- Aligned row: X0=0, X1=39, Y0=Y1=0, colour F, START at cycle 0. Expect SETUP at cycle 1, RAM_WREN at cycles 2-11 on addresses 0..9 with data 0xFFFF, and DONE at cycle 12. No reads are issued.
- Partial word: preload word 31 = 0x1234; fill X0=5, X1=6, Y=3, colour F. Expect one read of address 31, then a write of 0x1FF4 to address 31 (RD_LAT=1, 3 cycles), then DONE.
- CPU collision: same fill as the partial-word case, with CPU_REQ=1, CPU_WREN=1, CPU_ADDR=31, CPU_DATA=0xABCD during WAIT. Expect the engine to re-read and write 0xAFFD; the CPU write appears on RAM in its own cycle.
- Empty or clamped:
  - X0=10, X1=9: expect DONE 2 cycles after START and no RAM_WREN.
  - X0=36, X1=63, Y0=Y1=29: expect exactly one write, to address 299, with data 0xFFFF.
- Reset and busy: START a 40x30 fill, then pulse FILL_START again mid-fill. The second start is ignored. Then hold RST_N=0 for one cycle mid-fill: expect BUSY=0, DONE=0 and no engine RAM_WREN from the next cycle on.

Source files
------------

// File: rtl/gpu_fill_ctrl.sv
// Framebuffer port-A owner: muxes the CPU word path with a rectangle-fill engine.
// The CPU always wins the port; the engine paints 4-bit cells using RMW on partial words.
//
// state | meaning
// IDLE  | waiting for FILL_START
// SETUP | clamp bounds, reject empty rectangles, load first word
// RD    | present word address for a read (partial words only)
// WAIT  | RD_LAT cycles until RAM_Q is valid, merge on the last one
// WR    | engine write for one word, then advance
// DONE  | one-cycle completion pulse
module gpu_fill_ctrl #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int WPR    = 10,
  parameter int RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CPU_REQ,
  input  logic        CPU_WREN,
  input  logic [8:0]  CPU_ADDR,
  input  logic [15:0] CPU_DATA,
  output logic [15:0] CPU_Q,
  input  logic        FILL_START,
  input  logic [5:0]  FILL_X0,
  input  logic [5:0]  FILL_X1,
  input  logic [4:0]  FILL_Y0,
  input  logic [4:0]  FILL_Y1,
  input  logic [3:0]  FILL_COLOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [8:0]  RAM_ADDR,
  output logic [15:0] RAM_DATA,
  output logic        RAM_WREN,
  input  logic [15:0] RAM_Q
);

  localparam int            LW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] WAIT_LOAD = LW'(RD_LAT - 1);
  localparam logic [5:0]    X_MAX     = 6'(COLS - 1);
  localparam logic [4:0]    Y_MAX     = 5'(ROWS - 1);
  localparam logic [8:0]    WPR9      = 9'(WPR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     x0_q, x0_d, x1_q, x1_d;
  logic [4:0]     y0_q, y0_d, y1_q, y1_d;
  logic [3:0]     color_q, color_d;
  logic [4:0]     cur_y_q, cur_y_d;
  logic [3:0]     cur_w_q, cur_w_d;
  logic [8:0]     addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           full_q, full_d;
  logic [LW-1:0]  wcnt_q, wcnt_d;

  logic [5:0]     x1_clamp;
  logic [4:0]     y1_clamp;
  logic           load_word;
  logic [3:0]     next_mask;
  logic [15:0]    cur_bits;
  logic [15:0]    fill_word;

  // Bit 3 of the result is the leftmost cell of word w (bits [15:12]).
  function automatic logic [3:0] cell_mask(input logic [3:0] w, input logic [5:0] lo,
                                           input logic [5:0] hi);
    logic [6:0] c;
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      c = {1'b0, w, 2'b00} + 7'(i);
      m = {m[2:0], (c >= {1'b0, lo}) && (c <= {1'b0, hi})};
    end
    return m;
  endfunction

  function automatic logic [15:0] expand(input logic [3:0] m);
    return {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
  endfunction

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    color_d   = color_q;
    cur_y_d   = cur_y_q;
    cur_w_d   = cur_w_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    full_d    = full_q;
    wcnt_d    = wcnt_q;
    load_word = 1'b0;
    next_mask = '0;
    x1_clamp  = (x1_q > X_MAX) ? X_MAX : x1_q;
    y1_clamp  = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    fill_word = {4{color_q}};
    cur_bits  = expand(cell_mask(cur_w_q, x0_q, x1_q));

    case (state_q)
      S_IDLE: begin
        if (FILL_START) begin
          x0_d    = FILL_X0;
          x1_d    = FILL_X1;
          y0_d    = FILL_Y0;
          y1_d    = FILL_Y1;
          color_d = FILL_COLOR;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        x1_d = x1_clamp;
        y1_d = y1_clamp;
        if ((x0_q > x1_clamp) || (y0_q > y1_clamp)) begin
          state_d = S_DONE;
        end else begin
          cur_y_d   = y0_q;
          cur_w_d   = x0_q[5:2];
          load_word = 1'b1;
        end
      end
      S_RD: begin
        if (!CPU_REQ) begin
          wcnt_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (CPU_REQ) begin
          state_d = S_RD;
        end else if (wcnt_q == '0) begin
          wdata_d = (RAM_Q & ~cur_bits) | (fill_word & cur_bits);
          state_d = S_WR;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_WR: begin
        // A partial word is re-read after any CPU access so a fresh CPU write gets merged.
        if (CPU_REQ) begin
          if (!full_q) state_d = S_RD;
        end else if (cur_w_q < x1_q[5:2]) begin
          cur_w_d   = cur_w_q + 4'd1;
          load_word = 1'b1;
        end else if (cur_y_q == y1_q) begin
          state_d = S_DONE;
        end else begin
          cur_w_d   = x0_q[5:2];
          cur_y_d   = cur_y_q + 5'd1;
          load_word = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load_word) begin
      next_mask = cell_mask(cur_w_d, x0_q, x1_d);
      full_d    = &next_mask;
      addr_d    = 9'(cur_y_d) * WPR9 + 9'(cur_w_d);
      if (&next_mask) begin
        wdata_d = fill_word;
        state_d = S_WR;
      end else begin
        state_d = S_RD;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      cur_y_q <= '0;
      cur_w_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      full_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      cur_y_q <= cur_y_d;
      cur_w_q <= cur_w_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign BUSY     = (state_q == S_SETUP) || (state_q == S_RD) ||
                    (state_q == S_WAIT)  || (state_q == S_WR);
  assign DONE     = (state_q == S_DONE);
  assign CPU_Q    = RAM_Q;
  assign RAM_ADDR = CPU_REQ ? CPU_ADDR : addr_q;
  assign RAM_DATA = CPU_REQ ? CPU_DATA : wdata_q;
  assign RAM_WREN = CPU_REQ ? CPU_WREN : (state_q == S_WR);

endmodule

// File: tb/tb_gpu_fill_ctrl.sv
// Bench for gpu_fill_ctrl: directed scenarios plus random fills with random CPU traffic,
// checked against a cell-level framebuffer model and a per-word cycle-cost model.
module tb_gpu_fill_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CPU_REQ, CPU_WREN;
  logic [8:0]  CPU_ADDR;
  logic [15:0] CPU_DATA, CPU_Q;
  logic        FILL_START;
  logic [5:0]  FILL_X0, FILL_X1;
  logic [4:0]  FILL_Y0, FILL_Y1;
  logic [3:0]  FILL_COLOR;
  logic        BUSY, DONE;
  logic [8:0]  RAM_ADDR;
  logic [15:0] RAM_DATA, RAM_Q;
  logic        RAM_WREN;

  always #5 CLK = ~CLK;

  gpu_fill_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .CPU_REQ(CPU_REQ), .CPU_WREN(CPU_WREN), .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA),
    .CPU_Q(CPU_Q),
    .FILL_START(FILL_START), .FILL_X0(FILL_X0), .FILL_X1(FILL_X1),
    .FILL_Y0(FILL_Y0), .FILL_Y1(FILL_Y1), .FILL_COLOR(FILL_COLOR),
    .BUSY(BUSY), .DONE(DONE),
    .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_WREN(RAM_WREN), .RAM_Q(RAM_Q)
  );

  // Framebuffer RAM, one cycle read latency, read-old on same-address write.
  logic [15:0] mem [0:511];
  logic [15:0] ram_q;
  assign RAM_Q = ram_q;
  always @(posedge CLK) begin
    if (RAM_WREN) mem[RAM_ADDR] <= RAM_DATA;
    ram_q <= mem[RAM_ADDR];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          e_cyc[$];
  logic [8:0]  e_addr[$];
  logic [15:0] e_data[$];
  int          c_cyc[$];
  logic [8:0]  c_addr[$];
  logic [15:0] c_data[$];
  always @(negedge CLK) begin
    if (RAM_WREN && !CPU_REQ) begin
      e_cyc.push_back(cyc); e_addr.push_back(RAM_ADDR); e_data.push_back(RAM_DATA);
    end
    if (RAM_WREN && CPU_REQ) begin
      c_cyc.push_back(cyc); c_addr.push_back(RAM_ADDR); c_data.push_back(RAM_DATA);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: a 30x40 grid of colour cells.
  logic [3:0] cells [0:29][0:39];
  int f_x0, f_x1c, f_y0, f_y1c;
  bit f_empty;
  int e_base, c_base;

  function automatic logic [15:0] model_word(input int a);
    int y, w;
    y = a / 10; w = a % 10;
    return {cells[y][4*w], cells[y][4*w+1], cells[y][4*w+2], cells[y][4*w+3]};
  endfunction

  task automatic model_word_write(input int a, input logic [15:0] d);
    int y, w;
    y = a / 10; w = a % 10;
    cells[y][4*w]   = d[15:12];
    cells[y][4*w+1] = d[11:8];
    cells[y][4*w+2] = d[7:4];
    cells[y][4*w+3] = d[3:0];
  endtask

  task automatic model_fill(input logic [3:0] c);
    if (!f_empty)
      for (int y = f_y0; y <= f_y1c; y++)
        for (int x = f_x0; x <= f_x1c; x++) cells[y][x] = c;
  endtask

  function automatic bit in_fp(input int a);
    int y, w;
    y = a / 10; w = a % 10;
    return !f_empty && y >= f_y0 && y <= f_y1c && w >= f_x0 / 4 && w <= f_x1c / 4;
  endfunction

  function automatic int exp_cycles();
    int n;
    if (f_empty) return 2;
    n = 2;
    for (int y = f_y0; y <= f_y1c; y++)
      for (int w = f_x0 / 4; w <= f_x1c / 4; w++)
        n += (4 * w >= f_x0 && 4 * w + 3 <= f_x1c) ? 1 : 3;
    return n;
  endfunction

  function automatic int exp_words();
    if (f_empty) return 0;
    return (f_y1c - f_y0 + 1) * (f_x1c / 4 - f_x0 / 4 + 1);
  endfunction

  task automatic check_mem(input string tag);
    for (int a = 0; a < 300; a++) chk(tag, mem[a], model_word(a));
  endtask

  task automatic cpu_write(input int a, input logic [15:0] d);
    @(posedge CLK); #1;
    CPU_REQ = 1; CPU_WREN = 1; CPU_ADDR = 9'(a); CPU_DATA = d;
    model_word_write(a, d);
    @(posedge CLK); #1;
    CPU_REQ = 0; CPU_WREN = 0;
  endtask

  task automatic check_read(input int a);
    @(posedge CLK); #1;
    CPU_REQ = 1; CPU_WREN = 0; CPU_ADDR = 9'(a);
    @(posedge CLK); #1;
    CPU_REQ = 0;
    @(negedge CLK);
    chk("cpu_q", CPU_Q, model_word(a));
  endtask

  task automatic start_fill(input int x0, input int x1, input int y0, input int y1,
                            input logic [3:0] c, output int t0);
    @(posedge CLK); #1;
    FILL_X0 = 6'(x0); FILL_X1 = 6'(x1); FILL_Y0 = 5'(y0); FILL_Y1 = 5'(y1);
    FILL_COLOR = c; FILL_START = 1;
    t0 = cyc;
    e_base = e_addr.size(); c_base = c_addr.size();
    f_x0 = x0; f_x1c = (x1 > 39) ? 39 : x1;
    f_y0 = y0; f_y1c = (y1 > 29) ? 29 : y1;
    f_empty = (x0 > f_x1c) || (y0 > f_y1c);
    @(posedge CLK); #1;
    FILL_START = 0;
  endtask

  task automatic wait_done(input bit cpu_rand, output int dc);
    bit got;
    int a;
    got = 0; dc = -1;
    for (int n = 0; n < 4000 && !got; n++) begin
      @(negedge CLK);
      if (DONE) begin
        got = 1; dc = cyc;
        chk("busy_at_done", BUSY, 0);
      end else begin
        @(posedge CLK); #1;
        CPU_REQ = 0; CPU_WREN = 0;
        if (cpu_rand && $urandom_range(0, 3) == 0) begin
          a = int'($urandom_range(0, 299));
          CPU_REQ = 1; CPU_ADDR = 9'(a); CPU_DATA = 16'($urandom);
          CPU_WREN = !in_fp(a) && ($urandom_range(0, 1) == 1);
          if (CPU_WREN) model_word_write(a, CPU_DATA);
        end
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge CLK); #1;
    CPU_REQ = 0; CPU_WREN = 0;
    @(negedge CLK);
    chk("done_pulse_len", DONE, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dc, seq_ok, x0, x1, y0, y1;
    logic [3:0] col;
    bit cpu_rand;

    RST_N = 0; CPU_REQ = 0; CPU_WREN = 0; CPU_ADDR = '0; CPU_DATA = '0;
    FILL_START = 0; FILL_X0 = '0; FILL_X1 = '0; FILL_Y0 = '0; FILL_Y1 = '0; FILL_COLOR = '0;
    for (int y = 0; y < 30; y++) for (int x = 0; x < 40; x++) cells[y][x] = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_wren", RAM_WREN, 0);
    @(posedge CLK); #1;
    RST_N = 1;

    for (int a = 0; a < 300; a++) begin
      @(posedge CLK); #1;
      CPU_REQ = 1; CPU_WREN = 1; CPU_ADDR = 9'(a); CPU_DATA = 16'($urandom);
      model_word_write(a, CPU_DATA);
    end
    @(posedge CLK); #1;
    CPU_REQ = 0; CPU_WREN = 0;
    check_mem("preload");
    check_read(7);
    check_read(123);

    // Aligned full row
    start_fill(0, 39, 0, 0, 4'hF, t0);
    @(negedge CLK);
    chk("row_setup_busy", BUSY, 1);
    wait_done(0, dc);
    chk("row_done_cyc", dc - t0, 12);
    chk("row_writes", e_addr.size() - e_base, 10);
    if (e_addr.size() - e_base == 10)
      for (int i = 0; i < 10; i++) begin
        chk("row_addr", e_addr[e_base+i], i);
        chk("row_data", e_data[e_base+i], 16'hFFFF);
        chk("row_cyc", e_cyc[e_base+i] - t0, 2 + i);
      end
    model_fill(4'hF);

    // Partial word RMW
    cpu_write(31, 16'h1234);
    start_fill(5, 6, 3, 3, 4'hF, t0);
    wait_done(0, dc);
    chk("part_done_cyc", dc - t0, 5);
    chk("part_writes", e_addr.size() - e_base, 1);
    if (e_addr.size() > e_base) begin
      chk("part_addr", e_addr[e_base], 31);
      chk("part_data", e_data[e_base], 16'h1FF4);
      chk("part_cyc", e_cyc[e_base] - t0, 4);
    end
    model_fill(4'hF);

    // CPU write during WAIT forces a re-read
    cpu_write(31, 16'h1234);
    start_fill(5, 6, 3, 3, 4'hF, t0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    CPU_REQ = 1; CPU_WREN = 1; CPU_ADDR = 9'd31; CPU_DATA = 16'hABCD;
    model_word_write(31, 16'hABCD);
    @(posedge CLK); #1;
    CPU_REQ = 0; CPU_WREN = 0;
    wait_done(0, dc);
    chk("coll_done_cyc", dc - t0, 7);
    chk("coll_writes", e_addr.size() - e_base, 1);
    if (e_addr.size() > e_base) begin
      chk("coll_addr", e_addr[e_base], 31);
      chk("coll_data", e_data[e_base], 16'hAFFD);
    end
    chk("coll_cpu_writes", c_addr.size() - c_base, 1);
    if (c_addr.size() > c_base) begin
      chk("coll_cpu_cyc", c_cyc[c_base] - t0, 3);
      chk("coll_cpu_data", c_data[c_base], 16'hABCD);
    end
    model_fill(4'hF);
    chk("coll_mem", mem[31], 16'hAFFD);

    // Empty rectangle
    start_fill(10, 9, 0, 0, 4'h3, t0);
    wait_done(0, dc);
    chk("empty_done_cyc", dc - t0, 2);
    chk("empty_writes", e_addr.size() - e_base, 0);

    // Clamped corner
    start_fill(36, 63, 29, 29, 4'hF, t0);
    wait_done(0, dc);
    chk("clamp_done_cyc", dc - t0, 3);
    chk("clamp_writes", e_addr.size() - e_base, 1);
    if (e_addr.size() > e_base) begin
      chk("clamp_addr", e_addr[e_base], 299);
      chk("clamp_data", e_data[e_base], 16'hFFFF);
    end
    model_fill(4'hF);
    check_mem("directed_mem");

    // Second start ignored while busy, then reset mid-fill
    start_fill(0, 39, 0, 29, 4'h5, t0);
    repeat (19) begin @(posedge CLK); #1; end
    FILL_X0 = 6'd0; FILL_X1 = 6'd3; FILL_Y0 = 5'd0; FILL_Y1 = 5'd0; FILL_COLOR = 4'h2;
    FILL_START = 1;
    @(posedge CLK); #1;
    FILL_START = 0;
    repeat (19) begin @(posedge CLK); #1; end
    RST_N = 0;
    @(negedge CLK);
    chk("busy_before_rst", BUSY, 1);
    @(posedge CLK); #1;
    RST_N = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("post_rst_busy", BUSY, 0);
      chk("post_rst_done", DONE, 0);
    end
    chk("rst_writes", e_addr.size() - e_base, 39);
    seq_ok = 0;
    for (int i = 0; i < e_addr.size() - e_base; i++)
      if (e_addr[e_base+i] == 9'(i) && e_data[e_base+i] == 16'h5555 &&
          e_cyc[e_base+i] - t0 == i + 2) seq_ok++;
    chk("rst_seq", seq_ok, 39);
    for (int a = 0; a < 39; a++) model_word_write(a, 16'h5555);
    check_mem("rst_mem");

    // Random fills, alternating quiet and CPU-contended runs
    for (int k = 0; k < 14; k++) begin
      x0 = int'($urandom_range(0, 44));
      x1 = x0 + int'($urandom_range(0, 26)) - 2;
      if (x1 < 0) x1 = 0;
      if (x1 > 63) x1 = 63;
      y0 = int'($urandom_range(0, 31));
      y1 = y0 + int'($urandom_range(0, 6)) - 1;
      if (y1 < 0) y1 = 0;
      if (y1 > 31) y1 = 31;
      col = 4'($urandom);
      cpu_rand = (k % 2) == 1;
      start_fill(x0, x1, y0, y1, col, t0);
      wait_done(cpu_rand, dc);
      if (!cpu_rand) begin
        chk("rand_cycles", dc - t0, exp_cycles());
        chk("rand_writes", e_addr.size() - e_base, exp_words());
      end
      model_fill(col);
      check_mem("rand_mem");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
